// File: rtl/opdata_packer.sv
// Assembles a 3-4 beat draw command into the 74-bit opdata word for the shape splitter.
// A one-entry output register lets the next command assemble while the last one waits downstream.
module opdata_packer #(
  parameter int COLOR_W = 16,
  parameter int POS_W   = 19,
  parameter int OP_W    = 74
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [POS_W:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] opdata,
  output logic [3:0]      out_shape,
  output logic            err,
  output logic [7:0]      cmd_count
);

  localparam logic [3:0] SHAPE_LINE   = 4'd0;
  localparam logic [3:0] SHAPE_TRI    = 4'd1;
  localparam logic [3:0] SHAPE_CIRCLE = 4'd4;

  typedef enum logic [1:0] {IDLE, GET1, GET2, GET3} state_t;

  state_t               state;
  logic [3:0]           shape_p0;
  logic [COLOR_W-1:0]   color_p0;
  logic [POS_W-1:0]     pos1_p0;
  logic [POS_W-1:0]     pos2_p0;

  logic                 final_beat;
  logic                 in_fire;
  logic                 out_fire;
  logic                 load;
  logic [3:0]           beat_shape;
  logic [COLOR_W-1:0]   beat_color;
  logic [POS_W-1:0]     beat_pos;
  logic                 beat_fill;
  logic [OP_W-1:0]      load_word;

  function automatic logic shape_ok(input logic [3:0] code);
    return (code == SHAPE_LINE) || (code == SHAPE_TRI) || (code == SHAPE_CIRCLE);
  endfunction

  function automatic logic [OP_W-1:0] pack_word(
    input logic [COLOR_W-1:0] color,
    input logic [POS_W-1:0]   p1,
    input logic [POS_W-1:0]   p2,
    input logic [POS_W-1:0]   p3,
    input logic               fill
  );
    return {color, p1, p2, p3, fill};
  endfunction

  assign beat_shape = in_data[POS_W -: 4];
  assign beat_color = in_data[COLOR_W-1:0];
  assign beat_pos   = in_data[POS_W-1:0];
  assign beat_fill  = in_data[POS_W];

  // The last beat of a command writes straight into the output register, so it
  // may only be taken when that register is empty or draining this same cycle.
  assign final_beat = (state == GET3) || ((state == GET2) && (shape_p0 != SHAPE_TRI));
  assign in_ready   = !rst && (!final_beat || !out_valid || out_ready);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign load       = in_fire && final_beat;

  assign load_word = (state == GET3)
                   ? pack_word(color_p0, pos1_p0, pos2_p0, beat_pos, beat_fill)
                   : pack_word(color_p0, pos1_p0, beat_pos, '0, 1'b0);

  // Stage p0: beat assembly; output register loads from the final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shape_p0  <= '0;
      color_p0  <= '0;
      pos1_p0   <= '0;
      pos2_p0   <= '0;
      out_valid <= 1'b0;
      opdata    <= '0;
      out_shape <= '0;
      err       <= 1'b0;
      cmd_count <= '0;
    end else begin
      err <= 1'b0;

      if (load) begin
        out_valid <= 1'b1;
        opdata    <= load_word;
        out_shape <= shape_p0;
        cmd_count <= cmd_count + 8'd1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (in_fire) begin
        case (state)
          IDLE: begin
            if (shape_ok(beat_shape)) begin
              shape_p0 <= beat_shape;
              color_p0 <= beat_color;
              state    <= GET1;
            end else begin
              err <= 1'b1;
            end
          end
          GET1: begin
            pos1_p0 <= beat_pos;
            state   <= GET2;
          end
          GET2: begin
            pos2_p0 <= beat_pos;
            state   <= (shape_p0 == SHAPE_TRI) ? GET3 : IDLE;
          end
          GET3: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opdata_packer.sv
// Bench for opdata_packer: vector table, hand-written backpressure/reset/gap sequences,
// and randomized commands scored against a queue-based model of the opdata layout.
`timescale 1ns/1ps
module tb_opdata_packer;
  localparam int COLOR_W = 16;
  localparam int POS_W   = 19;
  localparam int OP_W    = 74;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [POS_W:0]  in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OP_W-1:0] opdata;
  logic [3:0]      out_shape;
  logic            err;
  logic [7:0]      cmd_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  opdata_packer #(.COLOR_W(COLOR_W), .POS_W(POS_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .opdata(opdata), .out_shape(out_shape),
    .err(err), .cmd_count(cmd_count)
  );

  typedef struct {
    logic [19:0] b0, b1, b2, b3;
    int          nbeats;
    logic [73:0] exp_op;
    logic [3:0]  exp_shape;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [73:0] op;
    logic [3:0]  sh;
  } exp_t;

  vec_t       tbl[5];
  exp_t       expq[$];
  logic [7:0] exp_count = '0;
  int         rdy_mode = 0;
  logic       mon_en = 1'b0;
  int         outs = 0;
  int         errs_seen = 0;
  int         bad_sent = 0;

  task automatic chk(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] word(input logic [15:0] c, input logic [18:0] p1,
                                       input logic [18:0] p2, input logic [18:0] p3, input logic f);
    return {c, p1, p2, p3, f};
  endfunction

  // Called half a cycle before... no: called at posedge+1; returns at posedge+1 after the handshake.
  task automatic beat(input logic [19:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("beat_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic gap_check(input int n, input logic [73:0] last);
    repeat (n) begin
      @(negedge clk);
      chk("gap_valid", out_valid, 1'b0);
      chk("gap_hold", opdata, last);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_opdata", opdata, '0);
    chk("rst_shape", out_shape, 4'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_count", cmd_count, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = '0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic rand_cmd();
    int          r   = int'($urandom_range(0, 9));
    logic [3:0]  code;
    logic [15:0] col = 16'($urandom());
    logic [19:0] b1  = 20'($urandom());
    logic [19:0] b2  = 20'($urandom());
    logic [19:0] b3  = 20'($urandom());
    logic        tri_cmd;
    exp_t        e;
    if (r < 3)      code = 4'd0;
    else if (r < 6) code = 4'd1;
    else if (r < 8) code = 4'd4;
    else begin
      code = 4'($urandom_range(2, 15));
      if (code == 4'd4) code = 4'd5;
    end
    tri_cmd = (code == 4'd1);
    beat({code, col});
    if (!(code == 4'd0 || code == 4'd1 || code == 4'd4)) begin
      bad_sent++;
      return;
    end
    idle(int'($urandom_range(0, 2)));
    beat(b1);
    idle(int'($urandom_range(0, 2)));
    beat(b2);
    if (tri_cmd) begin
      idle(int'($urandom_range(0, 2)));
      beat(b3);
    end
    e.op = word(col, b1[18:0], b2[18:0], tri_cmd ? b3[18:0] : 19'd0, tri_cmd ? b3[19] : 1'b0);
    e.sh = code;
    expq.push_back(e);
    exp_count++;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 2)      out_ready = ($urandom_range(0, 2) != 0);
    else if (rdy_mode == 1) out_ready = 1'b1;
  end

  initial begin : monitor
    logic        stall_prev = 1'b0;
    logic [73:0] prev_op = '0;
    logic [3:0]  prev_sh = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (err) errs_seen++;
        if (stall_prev) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_opdata", opdata, prev_op);
          chk("stall_shape", out_shape, prev_sh);
        end
        if (out_valid && out_ready) begin
          outs++;
          if (expq.size() == 0) chk("spurious_out", 1'b1, 1'b0);
          else begin
            e = expq.pop_front();
            chk("out_opdata", opdata, e.op);
            chk("out_shape", out_shape, e.sh);
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_op = opdata;
        prev_sh = out_shape;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [73:0] last, wa, wb;
    tbl[0] = '{20'h0F800, 20'h00A05, 20'h3FFFF, 20'h0, 3,
               {16'hF800, 19'h00A05, 19'h3FFFF, 19'h0, 1'b0}, 4'd0, 1'b0};
    tbl[1] = '{20'h107E0, 20'h00001, 20'h00002, 20'h80003, 4,
               {16'h07E0, 19'd1, 19'd2, 19'd3, 1'b1}, 4'd1, 1'b0};
    tbl[2] = '{20'h21234, 20'h0, 20'h0, 20'h0, 1, 74'h0, 4'd0, 1'b1};
    tbl[3] = '{20'h4041F, 20'h80123, 20'h80040, 20'h0, 3,
               {16'h041F, 19'h00123, 19'h00040, 19'h0, 1'b0}, 4'd4, 1'b0};
    tbl[4] = '{20'h1ABCD, 20'hFFFFF, 20'h00000, 20'h7FFFF, 4,
               {16'hABCD, 19'h7FFFF, 19'h0, 19'h7FFFF, 1'b0}, 4'd1, 1'b0};

    @(posedge clk); #1;
    do_reset();

    // Vector table, downstream always ready.
    out_ready = 1'b1;
    last = '0;
    for (int i = 0; i < 5; i++) begin
      beat(tbl[i].b0);
      if (tbl[i].nbeats == 1) begin
        @(negedge clk);
        chk($sformatf("v%0d_err", i), err, 1'b1);
        chk($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
        chk($sformatf("v%0d_no_out", i), out_valid, 1'b0);
        chk($sformatf("v%0d_count", i), cmd_count, exp_count);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d_err_pulse", i), err, 1'b0);
        @(posedge clk); #1;
      end else begin
        beat(tbl[i].b1);
        beat(tbl[i].b2);
        if (tbl[i].nbeats == 4) beat(tbl[i].b3);
        exp_count++;
        @(negedge clk);
        chk($sformatf("v%0d_valid", i), out_valid, 1'b1);
        chk($sformatf("v%0d_opdata", i), opdata, tbl[i].exp_op);
        chk($sformatf("v%0d_shape", i), out_shape, tbl[i].exp_shape);
        chk($sformatf("v%0d_count", i), cmd_count, exp_count);
        chk($sformatf("v%0d_err", i), err, tbl[i].exp_err);
        last = tbl[i].exp_op;
        @(posedge clk); #1;
      end
    end

    // Gaps between beats: state held, drained opdata keeps its last value.
    gap_check(1, last);
    beat(20'h0_1357);
    gap_check(3, last);
    beat(20'h0_0011);
    gap_check(2, last);
    beat(20'h0_0022);
    exp_count++;
    @(negedge clk);
    chk("gap_cmd_opdata", opdata, word(16'h1357, 19'h11, 19'h22, 19'h0, 1'b0));
    chk("gap_cmd_count", cmd_count, exp_count);
    @(posedge clk); #1;

    // Backpressure: second command's final beat stalls until the first drains.
    out_ready = 1'b0;
    wa = word(16'h1234, 19'd1, 19'd2, 19'd0, 1'b0);
    wb = word(16'h5678, 19'd3, 19'd4, 19'd0, 1'b0);
    beat(20'h0_1234); beat(20'h00001); beat(20'h00002);
    exp_count++;
    beat(20'h0_5678); beat(20'h00003);
    in_valid = 1'b1;
    in_data  = 20'h00004;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_stable", opdata, wa);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_count++;
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_opdata", opdata, wb);
    chk("bp_second_count", cmd_count, exp_count);

    // Reset mid-triangle with a held output.
    @(posedge clk); #1;
    beat(20'h1_00FF); beat(20'h00009);
    do_reset();
    out_ready = 1'b1;
    beat(20'h0_ABCD); beat(20'h00005); beat(20'h00006);
    exp_count++;
    @(negedge clk);
    chk("post_rst_opdata", opdata, word(16'hABCD, 19'd5, 19'd6, 19'd0, 1'b0));
    chk("post_rst_shape", out_shape, 4'd0);
    chk("post_rst_count", cmd_count, 8'd1);
    @(posedge clk); #1;

    // Wrap: 256 back-to-back line commands from reset.
    do_reset();
    rdy_mode = 1;
    outs = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] c = 16'($urandom());
      logic [19:0] p1 = 20'($urandom());
      logic [19:0] p2 = 20'($urandom());
      exp_t e;
      beat({4'd0, c}); beat(p1); beat(p2);
      e.op = word(c, p1[18:0], p2[18:0], 19'd0, 1'b0);
      e.sh = 4'd0;
      expq.push_back(e);
      exp_count++;
    end
    for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_drained", expq.size(), 0);
    chk("wrap_outs", outs, 256);
    chk("wrap_count", cmd_count, 8'd0);
    @(posedge clk); #1;

    // Randomized commands, gaps and backpressure.
    rdy_mode = 2;
    errs_seen = 0;
    bad_sent = 0;
    for (int i = 0; i < 300; i++) begin
      rand_cmd();
      idle(int'($urandom_range(0, 1)));
    end
    rdy_mode = 1;
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    mon_en = 1'b0;
    chk("rand_drained", expq.size(), 0);
    chk("rand_err_pulses", errs_seen, bad_sent);
    chk("rand_count", cmd_count, exp_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
